// File: rtl/and_sched_pkg.sv
// Shared types and constants for the AND-unit scheduler.
package and_sched_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_UNIT_LAT = 1;
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Requester ID width; never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/and_unit_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or after ptr, wrapping.
module rr_arbiter
  import and_sched_pkg::*;
#(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  always_comb begin
    int unsigned k;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    k         = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (32'(ptr) + i) % NREQ;
      if (!any && req[IDW'(k)]) begin
        any       = 1'b1;
        grant_idx = IDW'(k);
      end
    end
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/and_unit_scheduler.sv
// Shares one fixed-latency AND unit between NREQ requesters with round-robin
// grants and a valid/ready response port tagged with the owner's ID.
module and_unit_scheduler
  import and_sched_pkg::*;
#(
  parameter  int unsigned NREQ     = 2,
  parameter  int unsigned WIDTH    = DEF_WIDTH,
  parameter  int unsigned UNIT_LAT = DEF_UNIT_LAT,
  localparam int unsigned IDW      = id_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      unit_a,
  output logic [WIDTH-1:0]      unit_b,
  output logic                  unit_start,
  input  logic [WIDTH-1:0]      unit_y,
  output logic                  resp_valid,
  output logic [WIDTH-1:0]      resp_data,
  output logic [IDW-1:0]        resp_id,
  input  logic                  resp_ready,
  output logic                  busy
);

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   unit_a_q, unit_a_d;
  logic [WIDTH-1:0]   unit_b_q, unit_b_d;
  logic               start_q, start_d;
  logic [WIDTH-1:0]   resp_data_q, resp_data_d;
  logic [IDW-1:0]     resp_id_q, resp_id_d;
  logic               resp_valid_q, resp_valid_d;
  logic               busy_q, busy_d;

  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     grant_idx;
  logic               any;
  logic               grant_en;
  logic               xfer;
  logic [WIDTH-1:0]   a_slice [NREQ];
  logic [WIDTH-1:0]   b_slice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign a_slice[i] = req_a[i*WIDTH +: WIDTH];
    assign b_slice[i] = req_b[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Grants only from IDLE with enable, never while reset is asserted.
  assign grant_en  = (state_q == IDLE) && ena && !reset;
  assign req_ready = grant_en ? grant : '0;
  assign xfer      = grant_en && any;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    unit_a_d    = unit_a_q;
    unit_b_d    = unit_b_q;
    start_d     = 1'b0;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          unit_a_d  = a_slice[grant_idx];
          unit_b_d  = b_slice[grant_idx];
          resp_id_d = grant_idx;
          rr_ptr_d  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
          cnt_d     = CNT_W'(UNIT_LAT);
          start_d   = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // Counter hits zero in the cycle the unit result is valid.
        if (cnt_q == '0) begin
          resp_data_d = unit_y;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_valid_q && resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d       = (state_d != IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      unit_a_q     <= '0;
      unit_b_q     <= '0;
      start_q      <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      unit_a_q     <= unit_a_d;
      unit_b_q     <= unit_b_d;
      start_q      <= start_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign unit_a     = unit_a_q;
  assign unit_b     = unit_b_q;
  assign unit_start = start_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = busy_q;

endmodule

// File: doc/and_unit_scheduler.md
# and_unit_scheduler

Sequences and shares the single 8-bit bitwise-AND datapath unit between `NREQ` requesters. Requesters hand over operand pairs with a valid/ready handshake. A round-robin arbiter grants one requester at a time and the scheduler drives the unit's operand inputs. It waits the unit's fixed latency, then returns the result with the requester's ID on a valid/ready response port. The block sits between the top-level pin wrapper and the AND unit.

## Interface
- `NREQ`, 2 — number of requesters, 2..8
- `WIDTH`, 8 — operand/result width
- `UNIT_LAT`, 1 — unit latency in cycles from `unit_start` to a valid `unit_y`, 1..15
- `clk`  in  1  — single clock, rising edge
- `reset`  in  1  — synchronous, active-high reset
- `ena`  in  1  — grant enable; low blocks new grants only
- `req_valid`  in  NREQ  — per-requester operand valid
- `req_a`  in  NREQ*WIDTH  — operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- `req_b`  in  NREQ*WIDTH  — operand B; same packing as `req_a`
- `req_ready`  out  NREQ  — one-hot acceptance to the granted requester
- `unit_a`, `unit_b`  out  WIDTH  — operands to the AND unit, held stable while busy
- `unit_start`  out  1  — one-cycle start pulse to the unit
- `unit_y`  in  WIDTH  — unit result
- `resp_valid`  out  1  — result available
- `resp_data`  out  WIDTH  — captured `unit_y`
- `resp_id`  out  max(1,clog2(NREQ))  — index of the requester that owns the result
- `resp_ready`  in  1  — consumer accepts the result
- `busy`  out  1  — high in any state other than IDLE

## Operation
- FSM states:
  - IDLE → WAIT on a grant.
  - WAIT → RESP when the latency counter expires.
  - RESP → IDLE on `resp_valid && resp_ready`.
- Arbitration (IDLE, `ena`=1, `reset`=0):
  - Candidate set is `req_valid`.
  - The winner is the lowest index at or after `rr_ptr`, wrapping at NREQ.
  - `req_ready[winner]`=1 combinationally; all other `req_ready` bits are 0.
  - A transfer occurs when `req_valid[g] && req_ready[g]`.
  - On transfer: capture `req_a`/`req_b` slice g into `unit_a`/`unit_b`, store g as the ID, set `rr_ptr` = (g+1) mod NREQ.
- `req_ready` is all-zero outside IDLE, when `ena`=0, and during reset.
- A requester may drop `req_valid` before it is granted; no transfer occurs and no error is flagged.
- WAIT:
  - `unit_start`=1 in the first WAIT cycle only.
  - Counter loads UNIT_LAT.
  - `unit_y` is sampled into `resp_data` in the cycle the counter reaches 0.
- RESP: `resp_valid`=1. `resp_data` and `resp_id` are held stable until accepted.
- `ena` low mid-operation: the in-flight request completes normally; only new grants are blocked.
- The result is truncated to WIDTH, with no arithmetic growth (bitwise operation).
- Reset at any time:
  - FSM → IDLE, `rr_ptr`=0, any in-flight result discarded.
  - Outputs: `req_ready`=0, `unit_a`=0, `unit_b`=0, `unit_start`=0, `resp_valid`=0, `resp_data`=0, `resp_id`=0, `busy`=0.

## Timing
- Transfer in cycle T (IDLE):
  - T+1: WAIT, `unit_start`=1, operands valid.
  - Unit result valid in cycle T+1+UNIT_LAT; captured at the end of that cycle.
  - `resp_valid`=1 from T+2+UNIT_LAT.
- With `resp_ready` held high:
  - Response handshake in T+2+UNIT_LAT; IDLE in T+3+UNIT_LAT.
  - The next grant is possible in that same cycle.
  - Throughput is one request per UNIT_LAT+3 cycles.
- A response stalls indefinitely while `resp_ready`=0; no new grant is issued during the stall.
- `busy` is registered from FSM state and is high from T+1 through the response handshake cycle.

## Structure
- Shared package `and_sched_pkg`:
  - state enum (IDLE, WAIT, RESP)
  - default WIDTH / UNIT_LAT constants
  - function for ID width `max(1,clog2(n))`
- Sub-module `rr_arbiter`:
  - parameter NREQ
  - inputs: `req` vector, `ptr`
  - outputs: one-hot `grant`, `grant_idx`, `any`
  - purely combinational
- FSM, latency counter, operand/result registers and `rr_ptr` live in the top of this block.

## Test plan
- Reset and single request: reset for 2 cycles, then requester 0 presents a=0xF0, b=0x3C with UNIT_LAT=1 and a model AND unit.
  - Expect `req_ready`=0b01 in the grant cycle and `unit_start` one cycle later.
  - Expect `resp_valid` 3 cycles after the grant with `resp_data`=0x30, `resp_id`=0.
- Contention: both requesters valid continuously (r0 a=0xFF b=0x0F; r1 a=0xAA b=0xFF), `resp_ready`=1.
  - Expect grants in the order 0,1,0,1.
  - Expect responses 0x0F/id0, 0xAA/id1, alternating; one response every 4 cycles.
- Backpressure: hold `resp_ready`=0 for 5 cycles after `resp_valid` rises.
  - Expect `resp_data` and `resp_id` stable throughout.
  - Expect no `req_ready` while r1 stays valid.
  - Expect r1 granted in the cycle after acceptance.
- Latency parameter: UNIT_LAT=4, a=0x55, b=0x5F.
  - Expect `resp_valid` exactly 6 cycles after the grant with `resp_data`=0x55.
  - Expect `unit_a`/`unit_b` held through WAIT.
- Enable and reset mid-operation:
  - Drop `ena` in the WAIT state: the current response still completes and no further grant occurs until `ena`=1.
  - Assert `reset` during RESP: next cycle `resp_valid`=0, `busy`=0, `rr_ptr`=0, so r0 wins the next contention.
